vga_scanout: RTL and testbench

//  Display-side reader for the 640x480 4bpp video RAM: 153600 bytes, two pixels per byte.

---
 rtl/vga_scanout_if.sv | 22 ++
 rtl/vga_scanout.sv | 114 +++++++++++
 tb/tb_vga_scanout.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_scanout_if.sv
// Video RAM read port and pixel output bundle for vga_scanout.
// master = scanout side, slave = VRAM / palette side.
interface vga_scanout_if;
   logic [19:0] vram_addr;
   logic [7:0]  vram_data;
   logic [3:0]  pix;
   logic        de;
   logic        hsync;
   logic        vsync;
   logic        pix_stb;
   logic        frame_start;

   modport master (
      output vram_addr, pix, de, hsync, vsync, pix_stb, frame_start,
      input  vram_data
   );

   modport slave (
      input  vram_addr, pix, de, hsync, vsync, pix_stb, frame_start,
      output vram_data
   );
endinterface

// File: rtl/vga_scanout.sv
// 640x480@60 VGA scanout of a 4bpp VRAM (two pixels per byte) driven by a
// pixel clock enable derived from the system clock.
module vga_scanout #(
   parameter int unsigned CLKDIV = 4,
   parameter int unsigned H_ACT  = 640,
   parameter int unsigned H_FP   = 16,
   parameter int unsigned H_SYNC = 96,
   parameter int unsigned H_BP   = 48,
   parameter int unsigned V_ACT  = 480,
   parameter int unsigned V_FP   = 10,
   parameter int unsigned V_SYNC = 2,
   parameter int unsigned V_BP   = 33
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   vga_scanout_if.master vif
);
   localparam int unsigned H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
   localparam int unsigned DW    = $clog2(CLKDIV);

   localparam logic [DW-1:0] DIV_LAST   = DW'(CLKDIV - 1);
   localparam logic [9:0]    H_LAST     = 10'(H_TOT - 1);
   localparam logic [9:0]    V_LAST     = 10'(V_TOT - 1);
   localparam logic [9:0]    H_ACT_L    = 10'(H_ACT);
   localparam logic [9:0]    V_ACT_L    = 10'(V_ACT);
   localparam logic [9:0]    V_ROW_LAST = 10'(V_ACT - 1);
   localparam logic [9:0]    HS_BEG     = 10'(H_ACT + H_FP);
   localparam logic [9:0]    HS_END     = 10'(H_ACT + H_FP + H_SYNC - 1);
   localparam logic [9:0]    VS_BEG     = 10'(V_ACT + V_FP);
   localparam logic [9:0]    VS_END     = 10'(V_ACT + V_FP + V_SYNC - 1);
   localparam logic [19:0]   ROW_BYTES  = 20'(H_ACT / 2);

   logic          run;
   logic [DW-1:0] div;
   logic [9:0]    h, v;
   logic [19:0]   row_base;
   logic          pix_ce, act_n, hs_n, vs_n, first_n;
   logic          h0_c, de_c, hs_c, vs_c, first_c, vld_c;

   always_comb begin
      run     = rst && en;
      pix_ce  = (div == DIV_LAST);
      act_n   = (h < H_ACT_L) && (v < V_ACT_L);
      hs_n    = !((h >= HS_BEG) && (h <= HS_END));
      vs_n    = !((v >= VS_BEG) && (v <= VS_END));
      first_n = (h == '0) && (v == '0);
   end

   // Raster counters; row_base tracks v*H_ACT/2 by accumulation.
   always_ff @(posedge clk) begin
      if (!run) begin
         div      <= '0;
         h        <= '0;
         v        <= '0;
         row_base <= '0;
      end else begin
         div <= pix_ce ? '0 : div + 1'b1;
         if (pix_ce) begin
            if (h == H_LAST) begin
               h <= '0;
               v <= (v == V_LAST) ? '0 : v + 1'b1;
               if (v == V_LAST)
                  row_base <= '0;
               else if (v < V_ROW_LAST)
                  row_base <= row_base + ROW_BYTES;
            end else begin
               h <= h + 1'b1;
            end
         end
      end
   end

   // Each pix_ce issues the address for (h,v) and presents the previous
   // position, whose VRAM data has been stable for CLKDIV-1 clocks.
   always_ff @(posedge clk) begin
      if (!run) begin
         vif.vram_addr   <= '0;
         vif.pix         <= '0;
         vif.de          <= 1'b0;
         vif.hsync       <= 1'b1;
         vif.vsync       <= 1'b1;
         vif.pix_stb     <= 1'b0;
         vif.frame_start <= 1'b0;
         h0_c            <= 1'b0;
         de_c            <= 1'b0;
         hs_c            <= 1'b1;
         vs_c            <= 1'b1;
         first_c         <= 1'b0;
         vld_c           <= 1'b0;
      end else begin
         vif.pix_stb     <= 1'b0;
         vif.frame_start <= 1'b0;
         if (pix_ce) begin
            if (act_n)
               vif.vram_addr <= row_base + {11'd0, h[9:1]};
            h0_c    <= h[0];
            de_c    <= act_n;
            hs_c    <= hs_n;
            vs_c    <= vs_n;
            first_c <= first_n;
            vld_c   <= 1'b1;

            vif.pix         <= de_c ? (h0_c ? vif.vram_data[7:4] : vif.vram_data[3:0]) : '0;
            vif.de          <= de_c;
            vif.hsync       <= hs_c;
            vif.vsync       <= vs_c;
            vif.pix_stb     <= vld_c;
            vif.frame_start <= vld_c && first_c;
         end
      end
   end
endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout: a reduced-timing instance checked against a
// raster model, plus a default-timing instance for the full-size first line.
module tb_vga_scanout;
   localparam int CD = 3;
   localparam int HA = 16, HF = 2, HS = 3, HB = 3;
   localparam int VA = 6,  VF = 1, VS = 2, VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FR = HT * VT;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic en  = 1'b0;
   int   cyc = 0;
   int   mode = 0;
   int   n_chk = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   vga_scanout_if ifs ();
   vga_scanout_if ifd ();

   vga_scanout #(
      .CLKDIV(CD), .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
   ) u_small (
      .clk(clk), .rst(rst), .en(en), .vif(ifs)
   );

   vga_scanout u_dflt (
      .clk(clk), .rst(rst), .en(en), .vif(ifd)
   );

   function automatic logic [7:0] mem(input int a);
      case (mode)
         0:       return 8'hA5;
         1:       return a[7:0];
         default: return 8'hFF;
      endcase
   endfunction

   always @(posedge clk) begin
      ifs.vram_data <= mem(int'(ifs.vram_addr));
      ifd.vram_data <= 8'hA5;
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, got, exp, $time);
   endtask

   typedef struct packed {
      logic [3:0] pix;
      logic       de;
      logic       hs;
      logic       vs;
      logic       fs;
   } obs_t;

   obs_t        cap [VT][HT];
   int          k = 0;
   int          prev_stb = -1;
   int          prev_fs = -1;
   int unsigned max_addr = 0;
   logic [19:0] hold = '0;

   function automatic int baddr(input int x, input int y);
      return y * (HA / 2) + x / 2;
   endfunction

   function automatic bit act(input int x, input int y);
      return (x < HA) && (y < VA);
   endfunction

   // Raster model for the reduced instance: k is the index of the next strobe since restart.
   always @(posedge clk) begin : mon
      int x, y, xn, yn;
      logic [7:0] d;
      obs_t e, g;
      #1;
      if (!rst || !en) begin
         chk("reset_outputs",
             {3'b0, ifs.vram_addr, ifs.pix, ifs.de, ifs.hsync, ifs.vsync, ifs.pix_stb, ifs.frame_start},
             {3'b0, 20'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
         k = 0; prev_stb = -1; prev_fs = -1; hold = '0; max_addr = 0;
      end else begin
         if (ifs.vram_addr > max_addr) max_addr = ifs.vram_addr;
         if (ifs.pix_stb) begin
            x  = k % HT;       y  = (k / HT) % VT;
            xn = (k + 1) % HT; yn = ((k + 1) / HT) % VT;
            d  = mem(baddr(x, y));
            e.pix = act(x, y) ? ((x % 2 == 1) ? d[7:4] : d[3:0]) : 4'd0;
            e.de  = act(x, y);
            e.hs  = !(x >= HA + HF && x < HA + HF + HS);
            e.vs  = !(y >= VA + VF && y < VA + VF + VS);
            e.fs  = (x == 0 && y == 0);
            g = {ifs.pix, ifs.de, ifs.hsync, ifs.vsync, ifs.frame_start};
            chk("strobe_outputs", 32'(g), 32'(e));
            if (act(xn, yn)) hold = 20'(baddr(xn, yn));
            chk("vram_addr", 32'(ifs.vram_addr), 32'(hold));
            if (prev_stb >= 0) chk("strobe_period", cyc - prev_stb, CD);
            if (ifs.frame_start) begin
               if (prev_fs >= 0) chk("frame_period", cyc - prev_fs, FR * CD);
               prev_fs = cyc;
            end
            prev_stb = cyc;
            if (k < FR) cap[y][x] = g;
            k++;
         end
      end
   end

   task automatic wait_k(input int target);
      int n = 0;
      while (k < target && n < (target + 4) * CD + 20) begin
         @(posedge clk);
         n++;
      end
      #2;
      chk("wait_progress", 32'(k >= target), 1);
   endtask

   task automatic dstb(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 12 && !ok; n++) begin
         @(posedge clk);
         #1;
         if (ifd.pix_stb) ok = 1'b1;
      end
   endtask

   typedef struct {
      int         x;
      int         y;
      logic [7:0] exp;
   } vec_t;

   vec_t vt [16];

   initial begin : wd
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int t_prev, de_cnt, hs_cnt, hs_first, de_first0;

      // {pix, de, hsync, vsync, frame_start} with VRAM byte = address[7:0]
      vt[0]  = '{0,  0, {4'h0, 4'b1111}};
      vt[1]  = '{15, 5, {4'h2, 4'b1110}};
      vt[2]  = '{14, 5, {4'hF, 4'b1110}};
      vt[3]  = '{2,  2, {4'h1, 4'b1110}};
      vt[4]  = '{10, 3, {4'hD, 4'b1110}};
      vt[5]  = '{11, 3, {4'h1, 4'b1110}};
      vt[6]  = '{6,  4, {4'h3, 4'b1110}};
      vt[7]  = '{16, 0, {4'h0, 4'b0110}};
      vt[8]  = '{18, 1, {4'h0, 4'b0010}};
      vt[9]  = '{20, 1, {4'h0, 4'b0010}};
      vt[10] = '{21, 1, {4'h0, 4'b0110}};
      vt[11] = '{17, 2, {4'h0, 4'b0110}};
      vt[12] = '{0,  6, {4'h0, 4'b0110}};
      vt[13] = '{0,  7, {4'h0, 4'b0100}};
      vt[14] = '{23, 8, {4'h0, 4'b0100}};
      vt[15] = '{0,  9, {4'h0, 4'b0110}};

      repeat (4) @(posedge clk);
      #1;
      chk("dflt_reset",
          {3'b0, ifd.vram_addr, ifd.pix, ifd.de, ifd.hsync, ifd.vsync, ifd.pix_stb, ifd.frame_start},
          {3'b0, 20'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
      @(negedge clk);
      rst = 1'b1;
      en  = 1'b1;

      // Default timing: first line of a 0xA5 frame
      de_cnt = 0; hs_cnt = 0; hs_first = -1; de_first0 = -1; t_prev = 0;
      for (int i = 0; i <= 800; i++) begin
         dstb(ok);
         if (!ok) begin
            chk("dflt_strobe_present", 0, 1);
            break;
         end
         if (i == 0) begin
            chk("dflt_first_fs", 32'(ifd.frame_start), 1);
            chk("dflt_first_pix", 32'(ifd.pix), 32'h5);
            chk("dflt_first_de", 32'(ifd.de), 1);
         end else if (i == 1) begin
            chk("dflt_second_pix", 32'(ifd.pix), 32'hA);
            chk("dflt_second_fs", 32'(ifd.frame_start), 0);
            chk("dflt_stb_period", cyc - t_prev, 4);
            chk("dflt_addr_x2", 32'(ifd.vram_addr), 1);
         end
         if (i == 800) begin
            chk("dflt_line1_de", 32'(ifd.de), 1);
            chk("dflt_line1_addr", 32'(ifd.vram_addr), 320);
         end else begin
            if (ifd.de) de_cnt++;
            else if (de_first0 < 0) de_first0 = i;
            if (!ifd.hsync) begin
               hs_cnt++;
               if (hs_first < 0) hs_first = i;
            end
         end
         t_prev = cyc;
      end
      chk("dflt_de_count", de_cnt, 640);
      chk("dflt_de_fall", de_first0, 640);
      chk("dflt_hs_count", hs_cnt, 96);
      chk("dflt_hs_start", hs_first, 656);

      // Address-pattern frame, checked against the hand-computed table
      @(negedge clk); en = 1'b0; mode = 1;
      @(negedge clk); en = 1'b1;
      wait_k(FR + 1);
      for (int i = 0; i < 16; i++)
         chk($sformatf("table_%0d_%0d", vt[i].x, vt[i].y), 32'(cap[vt[i].y][vt[i].x]), 32'(vt[i].exp));
      chk("max_addr", max_addr, VA * HA / 2 - 1);

      // Blanking with all-ones data, then en dropped mid-frame
      @(negedge clk); en = 1'b0; mode = 2;
      @(negedge clk); en = 1'b1;
      wait_k(FR + 2 * HT + 10);
      @(negedge clk); en = 1'b0;
      repeat (10) @(negedge clk);
      en = 1'b1;
      wait_k(HT + 2);
      chk("restart_fs_seen", 32'(prev_fs >= 0), 1);

      // rst pulse mid-line with en held high
      wait_k(3 * HT + 5);
      @(negedge clk); rst = 1'b0;
      @(negedge clk); rst = 1'b1;
      wait_k(FR + 5);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
